// File: rtl/float_mac_pkg.sv
// Shared types and constants for the float MAC datapath.
// Sticky tracking in csa_seq_mul is enabled by defining CSA_MUL_STICKY_EN.
package float_mac_pkg;

  localparam int MANT_W = 24;
  localparam int CNT_W  = $clog2(MANT_W);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_t;

endpackage

// File: rtl/csa_seq_mul_if.sv
// Operand/product valid-ready bundle for csa_seq_mul.
// The sticky signal exists only when CSA_MUL_STICKY_EN is defined.
interface csa_seq_mul_if #(
  parameter int WIDTH = 24
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
`ifdef CSA_MUL_STICKY_EN
  logic               sticky;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, sticky
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, sticky
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
`endif

endinterface

// File: rtl/csa_row.sv
// WIDTH-bit 3:2 carry-save compressor row.
// Carry bit i carries weight i+1 relative to the inputs.
module csa_row #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_seq_mul.sv
// Sequential carry-save mantissa multiplier, one multiplier bit per cycle.
// Define CSA_MUL_STICKY_EN to add the sticky (|product[WIDTH-3:0]) output.
module csa_seq_mul
  import float_mac_pkg::*;
#(
  parameter int WIDTH = MANT_W
) (
  input logic         clk,
  input logic         rst,
  csa_seq_mul_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] STK_END = CW'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] pp;
  logic [WIDTH-1:0] s_n;
  logic [WIDTH-1:0] c_n;
  logic [WIDTH:0]   cpa;

  assign pp  = mp[0] ? mc : '0;
  assign cpa = {1'b0, s_q} + {1'b0, c_q};

  csa_row #(
    .WIDTH(WIDTH)
  ) u_row (
    .x(s_q),
    .y(c_q),
    .z(pp),
    .s(s_n),
    .c(c_n)
  );

`ifdef CSA_MUL_STICKY_EN
  // Only the bits that end up in product[WIDTH-3:0] feed sticky.
  logic stk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk        <= 1'b0;
      bus.sticky <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) stk <= 1'b0;
        end
        ACCUM: begin
          if (cnt < STK_END) stk <= stk | s_n[0];
        end
        RESOLVE: begin
          bus.sticky <= stk;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.product   <= '0;
      mc            <= '0;
      mp            <= '0;
      s_q           <= '0;
      c_q           <= '0;
      lo            <= '0;
      cnt           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mc           <= bus.a;
            mp           <= bus.b;
            s_q          <= '0;
            c_q          <= '0;
            lo           <= '0;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            state        <= ACCUM;
          end
        end
        ACCUM: begin
          // Sum bit 0 is final; carries are already one place up.
          lo  <= {s_n[0], lo[WIDTH-1:1]};
          s_q <= {1'b0, s_n[WIDTH-1:1]};
          c_q <= c_n;
          mp  <= mp >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= RESOLVE;
        end
        RESOLVE: begin
          bus.product   <= {cpa[WIDTH-1:0], lo};
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  cpa_no_carry: assert property (
    @(posedge clk) disable iff (rst)
    (state == RESOLVE) |-> !cpa[WIDTH]
  );

endmodule
